// File: rtl/shifter_seq_if.sv
// ---------------------------------------------------------------------------
// shifter_seq_if
//   Request/response bundle between a requester and the iterative shifter.
//
//   start  requester -> shifter  request strobe, honoured only while busy=0
//   In     requester -> shifter  16-bit operand, captured with start
//   Cnt    requester -> shifter  4-bit shift/rotate amount, captured with start
//   Op     requester -> shifter  00 rotl, 01 shl, 10 rotr, 11 shr
//   Out    shifter -> requester  registered result, updated only with done
//   busy   shifter -> requester  operation in progress
//   done   shifter -> requester  one-cycle pulse marking a fresh Out
// ---------------------------------------------------------------------------
interface shifter_seq_if;
    logic        start;
    logic [15:0] In;
    logic [3:0]  Cnt;
    logic [1:0]  Op;
    logic [15:0] Out;
    logic        busy;
    logic        done;

    modport master (
        output start, In, Cnt, Op,
        input  Out, busy, done
    );

    modport slave (
        input  start, In, Cnt, Op,
        output Out, busy, done
    );
endinterface

// File: rtl/shifter_seq.sv
// ---------------------------------------------------------------------------
// shifter_seq
//   Iterative 16-bit shifter/rotator. An accepted request is worked off one
//   bit position per clock (or four positions per clock while at least four
//   remain, when SHIFTER_SEQ_FAST_EN is defined). Results match the
//   combinational barrel shifter bit for bit; only the latency differs.
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    shifter_seq_if.slave (start/In/Cnt/Op in, Out/busy/done out)
//
//   Build option:
//     SHIFTER_SEQ_FAST_EN  defined   -> 4-position steps while count >= 4
//                          undefined -> 1-position steps only
//
//   Latency from the accepting edge to the edge that raises done is
//   max(Cnt,1) cycles (fast build: max(Cnt/4 + Cnt%4, 1)).
// ---------------------------------------------------------------------------
module shifter_seq (
    input  logic          clk,
    input  logic          rst_n,
    shifter_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t      state_reg,  state_next;
    logic [15:0] data_reg,   data_next;
    logic [3:0]  count_reg,  count_next;
    logic [1:0]  op_reg,     op_next;
    logic [15:0] out_reg,    out_next;
    logic        busy_reg,   busy_next;
    logic        done_reg,   done_next;

    logic        step_four;
    logic [15:0] stepped;
    logic [3:0]  count_dec;

    // One step of the selected operation, either 1 or 4 positions.
    function automatic logic [15:0] step_by(input logic [15:0] d,
                                            input logic [1:0]  op,
                                            input logic        four);
        logic [15:0] r;
        if (four) begin
            case (op)
                2'b00:   r = {d[11:0], d[15:12]};
                2'b01:   r = {d[11:0], 4'b0000};
                2'b10:   r = {d[3:0],  d[15:4]};
                default: r = {4'b0000, d[15:4]};
            endcase
        end else begin
            case (op)
                2'b00:   r = {d[14:0], d[15]};
                2'b01:   r = {d[14:0], 1'b0};
                2'b10:   r = {d[0],    d[15:1]};
                default: r = {1'b0,    d[15:1]};
            endcase
        end
        return r;
    endfunction

`ifdef SHIFTER_SEQ_FAST_EN
    assign step_four = (count_reg >= 4'd4);
`else
    assign step_four = 1'b0;
`endif

    assign stepped   = step_by(data_reg, op_reg, step_four);
    assign count_dec = step_four ? (count_reg - 4'd4) : (count_reg - 4'd1);

    // Next-state and output logic. Out/done/busy are registered so that the
    // final step and the result publication land on the same clock edge;
    // this is what makes a Cnt=1 request complete one edge after acceptance.
    // FIN is only entered for Cnt=0: it spends one cycle with nothing to
    // shift and publishes on its exit edge, giving the minimum latency of 1.
    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        count_next = count_reg;
        op_next    = op_reg;
        out_next   = out_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                // The done cycle is spent in IDLE, so a start presented
                // alongside done is accepted here (back-to-back operation).
                if (bus.start) begin
                    data_next  = bus.In;
                    count_next = bus.Cnt;
                    op_next    = bus.Op;
                    busy_next  = 1'b1;
                    state_next = (bus.Cnt == 4'd0) ? FIN : SHIFT;
                end
            end

            SHIFT: begin
                data_next  = stepped;
                count_next = count_dec;
                if (count_dec == 4'd0) begin
                    out_next   = stepped;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end

            FIN: begin
                out_next   = data_reg;
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            data_reg  <= 16'h0000;
            count_reg <= 4'd0;
            op_reg    <= 2'b00;
            out_reg   <= 16'h0000;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            count_reg <= count_next;
            op_reg    <= op_next;
            out_reg   <= out_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign bus.Out  = out_reg;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;

endmodule

// File: tb/tb_shifter_seq.sv
// ---------------------------------------------------------------------------
// tb_shifter_seq
//   Self-checking bench for shifter_seq. Expected results come from an
//   arithmetic model of the combinational shifter; expected latency comes
//   from the closed-form latency rule of the selected build.
// ---------------------------------------------------------------------------
module tb_shifter_seq;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    shifter_seq_if bus ();

    shifter_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational shifter model in plain 32-bit arithmetic.
    function automatic logic [15:0] ref_shift(input logic [15:0] a,
                                              input int          c,
                                              input logic [1:0]  o);
        int unsigned x;
        x = 32'(a);
        case (o)
            2'b00:   return 16'((x << c) | (x >> (16 - c)));
            2'b01:   return 16'(x << c);
            2'b10:   return 16'((x >> c) | (x << (16 - c)));
            default: return 16'(x >> c);
        endcase
    endfunction

    function automatic int ref_latency(input int c);
        int l;
`ifdef SHIFTER_SEQ_FAST_EN
        l = c / 4 + c % 4;
`else
        l = c;
`endif
        return (l < 1) ? 1 : l;
    endfunction

    // Wait up to 40 edges for done; checks busy stays high and Out holds.
    task automatic wait_done(input logic [15:0] prev_out, input string tag,
                             output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (bus.done === 1'b1) break;
            checks++;
            if (bus.busy !== 1'b1 || bus.Out !== prev_out) begin
                errors++;
                $display("FAIL %s hold: busy=%b Out=%h, required busy=1 Out=%h",
                         tag, bus.busy, bus.Out, prev_out);
            end
        end
    endtask

    task automatic do_op(input logic [15:0] a, input logic [3:0] c,
                         input logic [1:0] o, input string tag);
        logic [15:0] exp_out;
        logic [15:0] prev_out;
        int          exp_l;
        int          lat;
        exp_out  = ref_shift(a, int'(c), o);
        exp_l    = ref_latency(int'(c));
        prev_out = bus.Out;
        bus.start = 1'b1; bus.In = a; bus.Cnt = c; bus.Op = o;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.In = 16'($urandom); bus.Cnt = 4'($urandom); bus.Op = 2'($urandom);
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: busy=%b done=%b, required busy=1 done=0",
                     tag, bus.busy, bus.done);
        end
        wait_done(prev_out, tag, lat);
        checks++;
        if (bus.Out !== exp_out) begin
            errors++;
            $display("FAIL %s result: Out=%h, required %h", tag, bus.Out, exp_out);
        end
        checks++;
        if (lat !== exp_l) begin
            errors++;
            $display("FAIL %s latency: %0d, required %0d", tag, lat, exp_l);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_done: busy=%b, required 0", tag, bus.busy);
        end
        $display("%s In=%h Cnt=%0d Op=%b -> Out=%h lat=%0d", tag, a, c, o, bus.Out, lat);
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0 || bus.Out !== exp_out) begin
            errors++;
            $display("FAIL %s after_done: done=%b Out=%h, required done=0 Out=%h",
                     tag, bus.done, bus.Out, exp_out);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.In = 16'hFFFF; bus.Cnt = 4'd3; bus.Op = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.Out !== 16'h0000 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset: Out=%h busy=%b done=%b, required 0000/0/0",
                     bus.Out, bus.busy, bus.done);
        end
        $display("reset Out=%h busy=%b done=%b", bus.Out, bus.busy, bus.done);
    endtask

    task automatic test_directed();
        do_op(16'h8001, 4'd1,  2'b00, "rotl_wrap");
        do_op(16'hA0A0, 4'd4,  2'b01, "shl4");
        do_op(16'h0001, 4'd15, 2'b10, "rotr15");
        do_op(16'hFFFF, 4'd0,  2'b11, "shr0");
    endtask

    task automatic test_ignore_busy();
        int lat;
        int exp_l;
        int pulse_at;
        logic [15:0] prev_out;
        exp_l    = ref_latency(8);
        pulse_at = (exp_l > 3) ? 3 : 1;
        prev_out = bus.Out;
        bus.start = 1'b1; bus.In = 16'h1234; bus.Cnt = 4'd8; bus.Op = 2'b11;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        while (lat < 40) begin
            if (lat + 1 == pulse_at) begin
                bus.start = 1'b1; bus.In = 16'hABCD; bus.Cnt = 4'd1; bus.Op = 2'b00;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            lat++;
            if (bus.done === 1'b1) break;
            checks++;
            if (bus.busy !== 1'b1 || bus.Out !== prev_out) begin
                errors++;
                $display("FAIL ignore hold: busy=%b Out=%h, required busy=1 Out=%h",
                         bus.busy, bus.Out, prev_out);
            end
        end
        checks++;
        if (bus.Out !== 16'h0012) begin
            errors++;
            $display("FAIL ignore result: Out=%h, required 0012", bus.Out);
        end
        checks++;
        if (lat !== exp_l) begin
            errors++;
            $display("FAIL ignore latency: %0d, required %0d", lat, exp_l);
        end
        $display("ignore_busy In=1234 Cnt=8 Op=11 -> Out=%h lat=%0d", bus.Out, lat);
        // The ignored request must not be served later.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL ignore phantom: done=%b busy=%b, required 0/0",
                         bus.done, bus.busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [15:0] first_out;
        first_out = ref_shift(16'h8001, 3, 2'b00);
        bus.start = 1'b1; bus.In = 16'h8001; bus.Cnt = 4'd3; bus.Op = 2'b00;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(bus.Out, "b2b_first", lat);
        checks++;
        if (bus.done !== 1'b1 || bus.Out !== first_out) begin
            errors++;
            $display("FAIL b2b_first: done=%b Out=%h, required 1/%h",
                     bus.done, bus.Out, first_out);
        end
        $display("b2b_first In=8001 Cnt=3 Op=00 -> Out=%h lat=%0d", bus.Out, lat);
        // Present the second request during the done cycle.
        bus.start = 1'b1; bus.In = 16'h00F0; bus.Cnt = 4'd4; bus.Op = 2'b11;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b accept: busy=%b done=%b, required 1/0", bus.busy, bus.done);
        end
        wait_done(first_out, "b2b_second", lat);
        checks++;
        if (bus.Out !== 16'h000F) begin
            errors++;
            $display("FAIL b2b result: Out=%h, required 000F", bus.Out);
        end
        checks++;
        if (lat !== ref_latency(4)) begin
            errors++;
            $display("FAIL b2b latency: %0d, required %0d", lat, ref_latency(4));
        end
        $display("b2b_second In=00F0 Cnt=4 Op=11 -> Out=%h lat=%0d", bus.Out, lat);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int reset_at;
        reset_at = (ref_latency(12) > 5) ? 5 : ref_latency(12) - 1;
        bus.start = 1'b1; bus.In = 16'hFFFF; bus.Cnt = 4'd12; bus.Op = 2'b01;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (reset_at - 1) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.Out !== 16'h0000 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: Out=%h busy=%b done=%b, required 0000/0/0",
                     bus.Out, bus.busy, bus.done);
        end
        $display("mid_reset at cycle %0d Out=%h busy=%b done=%b",
                 reset_at, bus.Out, bus.busy, bus.done);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.Out !== 16'h0000) begin
                errors++;
                $display("FAIL post_reset: done=%b busy=%b Out=%h, required 0/0/0000",
                         bus.done, bus.busy, bus.Out);
            end
        end
        do_op(16'h00F0, 4'd4, 2'b11, "recover");
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            do_op(16'($urandom), 4'($urandom), 2'($urandom), $sformatf("rand%0d", i));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_directed();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
